// File: rtl/udp_serial_tx_if.sv
// Byte-stream load side and serial-line status of udp_serial_tx.
// The source drives data/valid/last; the transmitter drives everything else.
interface udp_serial_tx_if;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_last;
  logic       o_ready;
  logic       o_serial;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  modport master (
    output i_data, i_valid, i_last,
    input  o_ready, o_serial, o_busy, o_done, o_err
  );

  modport slave (
    input  i_data, i_valid, i_last,
    output o_ready, o_serial, o_busy, o_done, o_err
  );
endinterface

// File: rtl/udp_serial_tx.sv
// Buffers a UDP packet, optionally inserts the one's-complement checksum
// (define UDP_TX_CKSUM_EN), then sends start bit + bytes MSB first + idle gap.
//
// state | meaning
// LOAD  | accepting bytes into the buffer, o_ready high
// FINAL | checksum settles; short packets are dropped here
// START | one-cycle start bit
// SHIFT | data bits, byte 0 first, MSB first
// GAP   | GAP_CYCLES low idle cycles, o_done on the last one
module udp_serial_tx #(
  parameter int MAX_LEN    = 64,
  parameter int GAP_CYCLES = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  udp_serial_tx_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {LOAD, FINAL, START, SHIFT, GAP} state_t;

  state_t           state;
  logic [7:0]       pkt_mem [MAX_LEN];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rd_nxt;
  logic [2:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       sh;
  logic             accept;
  logic             last_byte;
  logic             drop;
  logic [7:0]       in_byte;

  assign accept    = (state == LOAD) && bus.o_ready && bus.i_valid;
  assign last_byte = bus.i_last || (wr_idx == IDX_W'(MAX_LEN - 1));
  // the checksum field is zero while summing and in the no-checksum build
  assign in_byte   = ((wr_idx == IDX_W'(6)) || (wr_idx == IDX_W'(7))) ? 8'h00 : bus.i_data;
  // o_err is only ever high during FINAL, so it doubles as the drop flag
  assign drop      = (state == FINAL) && bus.o_err;
  assign rd_nxt    = rd_idx + 1'b1;

`ifdef UDP_TX_CKSUM_EN
  logic [15:0] acc;
  logic [7:0]  hi_byte;
  logic [15:0] word;
  logic [16:0] sum;
  logic [15:0] cksum;

  always_comb begin
    word = wr_idx[0] ? {hi_byte, in_byte} : {in_byte, 8'h00};
    sum  = {1'b0, acc} + {1'b0, word};
  end

  assign cksum = (acc == 16'hFFFF) ? 16'hFFFF : ~acc;

  // acc is consumed in FINAL, so clearing it there leaves it zero on LOAD entry
  always_ff @(posedge i_clk) begin
    if (i_rst || (state == FINAL)) begin
      acc     <= 16'h0000;
      hi_byte <= 8'h00;
    end else if (accept) begin
      if (!wr_idx[0]) hi_byte <= in_byte;
      if (wr_idx[0] || last_byte) acc <= sum[15:0] + {15'd0, sum[16]};
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (drop) begin
      for (int i = 0; i < MAX_LEN; i++) pkt_mem[i] <= 8'h00;
    end else if (accept) begin
      pkt_mem[wr_idx] <= in_byte;
`ifdef UDP_TX_CKSUM_EN
    end else if (state == FINAL) begin
      pkt_mem[6] <= cksum[15:8];
      pkt_mem[7] <= cksum[7:0];
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= LOAD;
      wr_idx       <= '0;
      rd_idx       <= '0;
      bit_cnt      <= 3'd0;
      gap_cnt      <= '0;
      sh           <= 8'h00;
      bus.o_ready  <= 1'b0;
      bus.o_serial <= 1'b0;
      bus.o_busy   <= 1'b0;
      bus.o_done   <= 1'b0;
      bus.o_err    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          bus.o_ready <= 1'b1;
          if (accept) begin
            if (last_byte) begin
              state       <= FINAL;
              bus.o_ready <= 1'b0;
              bus.o_busy  <= 1'b1;
              bus.o_err   <= (wr_idx < IDX_W'(7));
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        FINAL: begin
          if (bus.o_err) begin
            state       <= LOAD;
            bus.o_err   <= 1'b0;
            bus.o_ready <= 1'b1;
            bus.o_busy  <= 1'b0;
            wr_idx      <= '0;
          end else begin
            state        <= START;
            bus.o_serial <= 1'b1;
          end
        end
        START: begin
          state        <= SHIFT;
          rd_idx       <= '0;
          bus.o_serial <= pkt_mem[0][7];
          sh           <= {pkt_mem[0][6:0], 1'b0};
          bit_cnt      <= 3'd7;
        end
        SHIFT: begin
          if (bit_cnt != 3'd0) begin
            bus.o_serial <= sh[7];
            sh           <= {sh[6:0], 1'b0};
            bit_cnt      <= bit_cnt - 1'b1;
          end else if (rd_idx == wr_idx) begin
            state        <= GAP;
            bus.o_serial <= 1'b0;
            gap_cnt      <= GAP_W'(GAP_CYCLES - 1);
          end else begin
            rd_idx       <= rd_nxt;
            bus.o_serial <= pkt_mem[rd_nxt][7];
            sh           <= {pkt_mem[rd_nxt][6:0], 1'b0};
            bit_cnt      <= 3'd7;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state       <= LOAD;
            bus.o_done  <= 1'b0;
            bus.o_ready <= 1'b1;
            bus.o_busy  <= 1'b0;
            wr_idx      <= '0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_cnt == GAP_W'(1)) bus.o_done <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_serial_tx.sv
// Bench for udp_serial_tx: fixed vectors, randomized packets against a
// one's-complement reference model, forced end at MAX_LEN, and mid-SHIFT reset.
module tb_udp_serial_tx;
  localparam int MAX_LEN = 64;
  localparam int GAP     = 3;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    int          n;
    logic [71:0] bytes;
    logic [15:0] ck;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  udp_serial_tx_if bus();

  udp_serial_tx #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: zero bytes 6/7, fold the 32-bit sum of big-endian words.
  function automatic bq_t model_tx(input bq_t pkt);
    bq_t         q;
    int unsigned total;
    logic [15:0] ck;
    q     = pkt;
    total = 0;
    ck    = 16'h0000;
    if (q.size() >= 8) begin
      q[6] = 8'h00;
      q[7] = 8'h00;
    end
`ifdef UDP_TX_CKSUM_EN
    for (int i = 0; i < q.size(); i += 2)
      total = total + 32'({q[i], (i + 1 < q.size()) ? q[i+1] : 8'h00});
    while (total > 32'h0000_FFFF) total = (total & 32'h0000_FFFF) + (total >> 16);
    ck = ~total[15:0];
    if (ck == 16'h0000) ck = 16'hFFFF;
    if (q.size() >= 8) begin
      q[6] = ck[15:8];
      q[7] = ck[7:0];
    end
`endif
    return q;
  endfunction

  task automatic send_bytes(input bq_t pkt, input bit gaps, input bit use_last);
    int i;
    int guard;
    i     = 0;
    guard = 0;
    while (i < pkt.size()) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.i_valid = 1'b0;
      end else begin
        bus.i_valid = 1'b1;
        bus.i_data  = pkt[i];
        bus.i_last  = use_last && (i == pkt.size() - 1);
        if (bus.o_ready) i++;
      end
      guard++;
      if (guard > 4000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: accepted %0d of %0d bytes", i, pkt.size());
        break;
      end
    end
    @(posedge clk);
  endtask

  // Called right after the edge accepting the last byte (cycle T).
  task automatic check_tx(input bq_t exp, input bit exp_err, input bit hold, input string tag);
    logic [7:0] b;
    int         done_at;
    int         done_cnt;
    bit         early;
    bit         gap_bad;
    bit         ready_bad;
    done_at   = 0;
    done_cnt  = 0;
    early     = 1'b0;
    gap_bad   = 1'b0;
    ready_bad = 1'b0;

    @(negedge clk);
    if (!hold) bus.i_valid = 1'b0;
    bus.i_last = 1'b0;
    chk({tag, " final_busy"}, bus.o_busy, 1);
    chk({tag, " final_ready"}, bus.o_ready, 0);
    chk({tag, " final_serial"}, bus.o_serial, 0);
    chk({tag, " err"}, bus.o_err, exp_err);
    if (exp_err) begin
      @(negedge clk);
      chk({tag, " drop_ready"}, bus.o_ready, 1);
      chk({tag, " drop_err_clr"}, bus.o_err, 0);
      chk({tag, " drop_serial"}, bus.o_serial, 0);
      return;
    end

    @(negedge clk);
    if (hold && bus.o_ready) ready_bad = 1'b1;
    chk({tag, " start_bit"}, bus.o_serial, 1);

    for (int j = 0; j < exp.size(); j++) begin
      b = 8'h00;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        b = {b[6:0], bus.o_serial};
        if (bus.o_done || bus.o_err) early = 1'b1;
        if (hold && bus.o_ready) ready_bad = 1'b1;
      end
      chk($sformatf("%s byte%0d", tag, j), b, exp[j]);
    end
    chk({tag, " no_early_pulse"}, early, 0);

    for (int g = 1; g <= GAP; g++) begin
      @(negedge clk);
      if (bus.o_serial) gap_bad = 1'b1;
      if (hold && bus.o_ready) ready_bad = 1'b1;
      if (bus.o_done) begin
        done_at = g;
        done_cnt++;
      end
    end
    chk({tag, " gap_low"}, gap_bad, 0);
    chk({tag, " done_cycle"}, done_at, GAP);
    chk({tag, " done_count"}, done_cnt, 1);

    @(negedge clk);
    if (hold) bus.i_valid = 1'b0;
    chk({tag, " idle_ready"}, bus.o_ready, 1);
    chk({tag, " idle_busy"}, bus.o_busy, 0);
    chk({tag, " idle_done"}, bus.o_done, 0);
    if (hold) chk({tag, " ready_low_while_busy"}, ready_bad, 0);
  endtask

  initial begin
    vec_t vecs[7];
    bq_t  pkt;
    bq_t  exp;
    int   len;
    bit   quiet;

    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_last  = 1'b0;

    vecs[0] = '{8, 72'h00_35_00_35_00_08_AA_BB_00, 16'hFF8D};
    vecs[1] = '{9, 72'h00_35_00_35_00_08_AA_BB_80, 16'h7F8D};
    vecs[2] = '{8, 72'hFF_FF_FF_FF_00_00_00_00_00, 16'hFFFF};
    vecs[3] = '{5, 72'h11_22_33_44_55_00_00_00_00, 16'h0000};
    vecs[4] = '{8, 72'h01_02_03_04_05_06_07_08_00, 16'hF6F3};
    vecs[5] = '{7, 72'hA1_B2_C3_D4_E5_F6_07_00_00, 16'h0000};
    vecs[6] = '{8, 72'h00_00_00_00_00_00_00_00_00, 16'hFFFF};

    repeat (3) @(negedge clk);
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_serial", bus.o_serial, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err", bus.o_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.o_ready, 1);

    foreach (vecs[v]) begin
      pkt = {};
      for (int i = 0; i < vecs[v].n; i++) pkt.push_back(vecs[v].bytes[71 - 8*i -: 8]);
      exp = pkt;
      if (vecs[v].n >= 8) begin
`ifdef UDP_TX_CKSUM_EN
        exp[6] = vecs[v].ck[15:8];
        exp[7] = vecs[v].ck[7:0];
`else
        exp[6] = 8'h00;
        exp[7] = 8'h00;
`endif
      end
      send_bytes(pkt, 1'b0, 1'b1);
      check_tx(exp, vecs[v].n < 8, 1'b0, $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 12; r++) begin
      len = (r % 4 == 3) ? int'($urandom_range(1, 7)) : int'($urandom_range(8, 24));
      pkt = {};
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      send_bytes(pkt, 1'b1, 1'b1);
      check_tx(model_tx(pkt), len < 8, 1'b0, $sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // i_last never asserted, valid held high: packet must close at MAX_LEN
    pkt = {};
    for (int i = 0; i < MAX_LEN; i++) pkt.push_back(8'($urandom));
    send_bytes(pkt, 1'b0, 1'b0);
    check_tx(model_tx(pkt), 1'b0, 1'b1, "maxlen_hold");

    // reset while byte 3 (all ones) is being shifted out
    pkt = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(pkt, 1'b0, 1'b1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_serial", bus.o_serial, 0);
    chk("midrst_ready", bus.o_ready, 0);
    chk("midrst_busy", bus.o_busy, 0);
    @(negedge clk);
    chk("midrst_ready_release", bus.o_ready, 1);
    quiet = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.o_done || bus.o_err || bus.o_serial) quiet = 1'b1;
    end
    chk("midrst_quiet", quiet, 0);

    pkt = {};
    for (int i = 0; i < 8; i++) pkt.push_back(vecs[0].bytes[71 - 8*i -: 8]);
    send_bytes(pkt, 1'b0, 1'b1);
    check_tx(model_tx(pkt), 1'b0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
